decode_scoreboard_rf: RTL and testbench

Parametrised register-read and scoreboard stage for the 5-stage pipeline, placed between Fetch and Execute. It holds the scalar register file and the condition code. Per-register pending-write counters let several writes to the same register be in flight at once. Writebacks from NUM_WB ports are bypassed into the same-cycle read. Valid/ready handshakes on both sides replace the stall flags.

---
 rtl/decode_scoreboard_rf_if.sv | 55 +++++
 rtl/decode_scoreboard_rf.sv | 190 +++++++++++++++++++
 tb/tb_decode_scoreboard_rf.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_scoreboard_rf_if.sv
// decode_scoreboard_rf_if
//   Bundles the Fetch-side instruction handshake, the writeback ports and
//   the Execute-side output register of the decode/scoreboard stage.
//   master : upstream/downstream environment (drives I_*, observes O_*)
//   slave  : the decode_scoreboard_rf stage (observes I_*, drives O_*)
interface decode_scoreboard_rf_if #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REGS  = 16,
    parameter int PC_WIDTH  = 32,
    parameter int OPC_WIDTH = 8,
    parameter int NUM_WB    = 2
);
    localparam int IDX_W = $clog2(NUM_REGS);

    // Fetch side
    logic                        I_Valid;
    logic                        O_Ready;
    logic [PC_WIDTH-1:0]         I_PC;
    logic [OPC_WIDTH-1:0]        I_Opcode;
    logic                        I_Src1En, I_Src2En, I_DestEn;
    logic [IDX_W-1:0]            I_Src1Idx, I_Src2Idx, I_DestIdx;
    logic [REG_WIDTH-1:0]        I_Imm;
    // Writeback ports (port p packed at [p*W +: W])
    logic [NUM_WB-1:0]           I_WbEn;
    logic [NUM_WB*IDX_W-1:0]     I_WbIdx;
    logic [NUM_WB*REG_WIDTH-1:0] I_WbData;
    logic [NUM_WB-1:0]           I_WbSetCC;
    // Execute side
    logic                        O_Valid;
    logic                        I_Ready;
    logic [PC_WIDTH-1:0]         O_PC;
    logic [OPC_WIDTH-1:0]        O_Opcode;
    logic [REG_WIDTH-1:0]        O_Imm;
    logic                        O_DestEn;
    logic [IDX_W-1:0]            O_DestIdx;
    logic [REG_WIDTH-1:0]        O_Src1Value, O_Src2Value;
    logic [2:0]                  O_CC;
    logic [31:0]                 O_StallCount;

    modport master (
        output I_Valid, I_PC, I_Opcode, I_Src1En, I_Src2En, I_DestEn,
               I_Src1Idx, I_Src2Idx, I_DestIdx, I_Imm,
               I_WbEn, I_WbIdx, I_WbData, I_WbSetCC, I_Ready,
        input  O_Ready, O_Valid, O_PC, O_Opcode, O_Imm, O_DestEn, O_DestIdx,
               O_Src1Value, O_Src2Value, O_CC, O_StallCount
    );

    modport slave (
        input  I_Valid, I_PC, I_Opcode, I_Src1En, I_Src2En, I_DestEn,
               I_Src1Idx, I_Src2Idx, I_DestIdx, I_Imm,
               I_WbEn, I_WbIdx, I_WbData, I_WbSetCC, I_Ready,
        output O_Ready, O_Valid, O_PC, O_Opcode, O_Imm, O_DestEn, O_DestIdx,
               O_Src1Value, O_Src2Value, O_CC, O_StallCount
    );
endinterface

// File: rtl/decode_scoreboard_rf.sv
// decode_scoreboard_rf
//   Register-read / scoreboard stage between Fetch and Execute. Holds the
//   register file and condition code, tracks in-flight writes per register
//   with small counters, bypasses same-cycle writebacks into operand reads,
//   and registers the issued instruction for Execute (1-cycle latency).
// Ports
//   I_CLOCK   : clock, all state on rising edge
//   I_RESET_N : asynchronous active-low reset
//   bus       : decode_scoreboard_rf_if.slave (handshakes, WB ports, outputs)
module decode_scoreboard_rf #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REGS  = 16,
    parameter int PC_WIDTH  = 32,
    parameter int OPC_WIDTH = 8,
    parameter int NUM_WB    = 2,
    parameter int PEND_BITS = 2
) (
    input logic                  I_CLOCK,
    input logic                  I_RESET_N,
    decode_scoreboard_rf_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REGS);

    typedef logic [IDX_W-1:0]     idx_t;
    typedef logic [REG_WIDTH-1:0] word_t;
    typedef logic [PEND_BITS-1:0] cnt_t;
    typedef logic [PEND_BITS:0]   cnt_ext_t;   // one spare bit for +1 before -N

    localparam cnt_t PEND_MAX = '1;

    typedef struct packed {
        logic [PC_WIDTH-1:0]  pc;
        logic [OPC_WIDTH-1:0] opcode;
        word_t                imm;
        logic                 dest_en;
        idx_t                 dest_idx;
        word_t                src1;
        word_t                src2;
    } out_t;

    // Unpacked view of the writeback ports
    logic [NUM_WB-1:0] wb_en, wb_set_cc;
    idx_t              wb_idx  [NUM_WB];
    word_t             wb_data [NUM_WB];

    assign wb_en     = bus.I_WbEn;
    assign wb_set_cc = bus.I_WbSetCC;
    for (genvar p = 0; p < NUM_WB; p++) begin : g_wb_unpack
        assign wb_idx[p]  = bus.I_WbIdx[p*IDX_W +: IDX_W];
        assign wb_data[p] = bus.I_WbData[p*REG_WIDTH +: REG_WIDTH];
    end

    word_t       rf_q  [NUM_REGS], rf_d  [NUM_REGS];
    cnt_t        cnt_q [NUM_REGS], cnt_d [NUM_REGS];
    logic [2:0]  cc_q, cc_d;
    logic [31:0] stall_q, stall_d;
    logic        valid_q, valid_d;
    out_t        out_q, out_d;

    logic src1_rdy, src2_rdy, dep_stall, ready, issue, wb_underflow;

    // Number of enabled writeback ports targeting idx this cycle
    function automatic cnt_ext_t wb_hits(input idx_t idx);
        wb_hits = '0;
        for (int p = 0; p < NUM_WB; p++)
            if (wb_en[p] && wb_idx[p] == idx) wb_hits = wb_hits + cnt_ext_t'(1);
    endfunction

    // RF read with bypass; the highest-numbered matching port wins
    function automatic word_t read_operand(input idx_t idx);
        read_operand = rf_q[idx];
        for (int p = 0; p < NUM_WB; p++)
            if (wb_en[p] && wb_idx[p] == idx) read_operand = wb_data[p];
    endfunction

    // A source is ready when every outstanding write to it retires this cycle
    function automatic logic src_ready(input logic en, input idx_t idx);
        src_ready = !en || cnt_q[idx] == '0 || {1'b0, cnt_q[idx]} == wb_hits(idx);
    endfunction

    // Handshake and output register
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned and no latch is inferred.
        valid_d  = valid_q;
        out_d    = out_q;
        stall_d  = stall_q;
        src1_rdy = src_ready(bus.I_Src1En, bus.I_Src1Idx);
        src2_rdy = src_ready(bus.I_Src2En, bus.I_Src2Idx);
        dep_stall = bus.I_Valid &
                    (~src1_rdy | ~src2_rdy |
                     (bus.I_DestEn & (cnt_q[bus.I_DestIdx] == PEND_MAX)));
        ready = ~dep_stall & (~valid_q | bus.I_Ready);
        issue = bus.I_Valid & ready;

        if (issue) begin
            valid_d        = 1'b1;
            out_d.pc       = bus.I_PC;
            out_d.opcode   = bus.I_Opcode;
            out_d.imm      = bus.I_Imm;
            out_d.dest_en  = bus.I_DestEn;
            out_d.dest_idx = bus.I_DestIdx;
            out_d.src1     = bus.I_Src1En ? read_operand(bus.I_Src1Idx) : '0;
            out_d.src2     = bus.I_Src2En ? read_operand(bus.I_Src2Idx) : '0;
        end else if (bus.I_Ready) begin
            valid_d = 1'b0;
        end

        if (dep_stall && stall_q != '1) stall_d = stall_q + 32'd1;
    end

    // Writebacks: later ports overwrite earlier ones in both RF and CC
    always_comb begin
        rf_d = rf_q;
        cc_d = cc_q;
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_en[p]) begin
                rf_d[wb_idx[p]] = wb_data[p];
                if (wb_set_cc[p]) begin
                    if (wb_data[p][REG_WIDTH-1]) cc_d = 3'b100;
                    else if (wb_data[p] == '0)   cc_d = 3'b010;
                    else                         cc_d = 3'b001;
                end
            end
        end
    end

    // Pending counters: +1 on issue with dest, -1 per retiring WB, floor at 0
    always_comb begin
        cnt_ext_t sum, dec;
        wb_underflow = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            sum = {1'b0, cnt_q[r]} +
                  cnt_ext_t'(issue && bus.I_DestEn && bus.I_DestIdx == idx_t'(r));
            dec = wb_hits(idx_t'(r));
            if (dec > sum) begin
                cnt_d[r]     = '0;
                wb_underflow = 1'b1;
            end else begin
                cnt_d[r] = cnt_t'(sum - dec);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of evaluation order.
    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            // NOTE: the register file is cleared on reset because software
            // may read registers before writing them; this forces flops
            // rather than a RAM macro.
            for (int r = 0; r < NUM_REGS; r++) begin
                rf_q[r]  <= '0;
                cnt_q[r] <= '0;
            end
            cc_q    <= '0;
            stall_q <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                rf_q[r]  <= rf_d[r];
                cnt_q[r] <= cnt_d[r];
            end
            cc_q    <= cc_d;
            stall_q <= stall_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

`ifndef SYNTHESIS
    // Writeback with no matching pending write: the RF still takes the data
    always @(posedge I_CLOCK)
        if (I_RESET_N && wb_underflow)
            $display("WARNING: decode_scoreboard_rf: writeback to register with no pending write");
`endif

    assign bus.O_Ready      = ready;
    assign bus.O_Valid      = valid_q;
    assign bus.O_PC         = out_q.pc;
    assign bus.O_Opcode     = out_q.opcode;
    assign bus.O_Imm        = out_q.imm;
    assign bus.O_DestEn     = out_q.dest_en;
    assign bus.O_DestIdx    = out_q.dest_idx;
    assign bus.O_Src1Value  = out_q.src1;
    assign bus.O_Src2Value  = out_q.src2;
    assign bus.O_CC         = cc_q;
    assign bus.O_StallCount = stall_q;
endmodule

// File: tb/tb_decode_scoreboard_rf.sv
// tb_decode_scoreboard_rf
//   Scoreboard bench for decode_scoreboard_rf: a driver applies directed and
//   random stimulus, evaluates a behavioural model (arrays of register values
//   and pending counts) and queues the expected issued instruction; a monitor
//   compares the DUT output register against the queue head.
module tb_decode_scoreboard_rf;
    localparam int RW = 32, NR = 16, PW = 32, OW = 8, NW = 2, PB = 2;
    localparam int PEND_MAX = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_scoreboard_rf_if #(.REG_WIDTH(RW), .NUM_REGS(NR), .PC_WIDTH(PW),
                              .OPC_WIDTH(OW), .NUM_WB(NW)) bus ();

    decode_scoreboard_rf #(.REG_WIDTH(RW), .NUM_REGS(NR), .PC_WIDTH(PW),
                           .OPC_WIDTH(OW), .NUM_WB(NW), .PEND_BITS(PB)) dut (
        .I_CLOCK   (clk),
        .I_RESET_N (rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [7:0]  opc;
        logic [31:0] imm;
        logic        den;
        logic [3:0]  didx;
        logic [31:0] s1;
        logic [31:0] s2;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    logic [31:0] m_rf [NR];
    int          m_pend [NR];
    logic [2:0]  m_cc;
    longint      m_stall;
    bit          m_ov;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_rf[r]   = '0;
            m_pend[r] = 0;
        end
        m_cc    = '0;
        m_stall = 0;
        m_ov    = 1'b0;
    endtask

    task automatic idle();
        bus.I_Valid   = 1'b0;
        bus.I_PC      = '0;
        bus.I_Opcode  = '0;
        bus.I_Imm     = '0;
        bus.I_Src1En  = 1'b0;
        bus.I_Src2En  = 1'b0;
        bus.I_DestEn  = 1'b0;
        bus.I_Src1Idx = '0;
        bus.I_Src2Idx = '0;
        bus.I_DestIdx = '0;
        bus.I_WbEn    = '0;
        bus.I_WbIdx   = '0;
        bus.I_WbData  = '0;
        bus.I_WbSetCC = '0;
        bus.I_Ready   = 1'b1;
    endtask

    task automatic set_instr(input bit s1en, input int s1, input bit s2en, input int s2,
                             input bit den, input int d);
        idle();
        bus.I_Valid   = 1'b1;
        bus.I_PC      = $urandom;
        bus.I_Opcode  = 8'($urandom);
        bus.I_Imm     = $urandom;
        bus.I_Src1En  = s1en;
        bus.I_Src1Idx = 4'(s1);
        bus.I_Src2En  = s2en;
        bus.I_Src2Idx = 4'(s2);
        bus.I_DestEn  = den;
        bus.I_DestIdx = 4'(d);
    endtask

    task automatic set_wb(input int p, input int idx, input logic [31:0] data, input bit setcc);
        bus.I_WbEn[p]          = 1'b1;
        bus.I_WbIdx[p*4 +: 4]  = 4'(idx);
        bus.I_WbData[p*32 +: 32] = data;
        bus.I_WbSetCC[p]       = setcc;
    endtask

    // Called at a falling edge with inputs applied: checks the current
    // state, predicts this cycle's handshake, advances the model by one edge
    // and returns at the next falling edge.
    task automatic step();
        int          hits [NR];
        logic [31:0] byp  [NR];
        bit          r1, r2, dep, exp_rdy, iss;
        int          s1, s2, d, n;
        exp_t        e;
        #1;
        check("stall_count", bus.O_StallCount, m_stall[31:0]);
        check("cc", bus.O_CC, m_cc);
        for (int r = 0; r < NR; r++) begin
            hits[r] = 0;
            byp[r]  = '0;
        end
        for (int p = 0; p < NW; p++)
            if (bus.I_WbEn[p]) begin
                hits[bus.I_WbIdx[p*4 +: 4]]++;
                byp[bus.I_WbIdx[p*4 +: 4]] = bus.I_WbData[p*32 +: 32];
            end
        s1 = int'(bus.I_Src1Idx);
        s2 = int'(bus.I_Src2Idx);
        d  = int'(bus.I_DestIdx);
        r1 = !bus.I_Src1En || m_pend[s1] == 0 || m_pend[s1] == hits[s1];
        r2 = !bus.I_Src2En || m_pend[s2] == 0 || m_pend[s2] == hits[s2];
        dep = bus.I_Valid && (!r1 || !r2 || (bus.I_DestEn && m_pend[d] == PEND_MAX));
        exp_rdy = !dep && (!m_ov || bus.I_Ready);
        check("o_ready", bus.O_Ready, exp_rdy);
        iss = bus.I_Valid && exp_rdy;
        if (iss) begin
            e.pc   = bus.I_PC;
            e.opc  = bus.I_Opcode;
            e.imm  = bus.I_Imm;
            e.den  = bus.I_DestEn;
            e.didx = bus.I_DestIdx;
            e.s1   = !bus.I_Src1En ? 32'd0 : (hits[s1] > 0 ? byp[s1] : m_rf[s1]);
            e.s2   = !bus.I_Src2En ? 32'd0 : (hits[s2] > 0 ? byp[s2] : m_rf[s2]);
            sbq.push_back(e);
        end
        // advance the model across the next rising edge
        if (dep && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (iss) m_ov = 1'b1;
        else if (bus.I_Ready) m_ov = 1'b0;
        for (int p = 0; p < NW; p++)
            if (bus.I_WbEn[p]) begin
                m_rf[bus.I_WbIdx[p*4 +: 4]] = bus.I_WbData[p*32 +: 32];
                if (bus.I_WbSetCC[p]) begin
                    if ($signed(bus.I_WbData[p*32 +: 32]) > 0)      m_cc = 3'b001;
                    else if ($signed(bus.I_WbData[p*32 +: 32]) < 0) m_cc = 3'b100;
                    else                                            m_cc = 3'b010;
                end
            end
        for (int r = 0; r < NR; r++) begin
            n = m_pend[r] + ((iss && bus.I_DestEn && d == r) ? 1 : 0) - hits[r];
            m_pend[r] = (n < 0) ? 0 : n;
        end
        @(negedge clk);
    endtask

    // Monitor: whenever the output register holds an instruction it must
    // match the oldest expected entry; it retires when Execute accepts.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.O_Valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_o_valid", bus.O_Valid, 1'b0);
                end else begin
                    e = sbq[0];
                    check("o_pc", bus.O_PC, e.pc);
                    check("o_opcode", bus.O_Opcode, e.opc);
                    check("o_imm", bus.O_Imm, e.imm);
                    check("o_dest_en", bus.O_DestEn, e.den);
                    check("o_dest_idx", bus.O_DestIdx, e.didx);
                    check("o_src1", bus.O_Src1Value, e.s1);
                    check("o_src2", bus.O_Src2Value, e.s2);
                    if (bus.I_Ready) void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int          avail [NR];
        int          r;
        logic [31:0] data;

        idle();
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_o_valid", bus.O_Valid, 1'b0);
        check("reset_o_cc", bus.O_CC, 3'b000);
        check("reset_stall_count", bus.O_StallCount, 32'd0);
        check("reset_o_pc", bus.O_PC, 32'd0);
        check("reset_o_src1", bus.O_Src1Value, 32'd0);
        check("reset_o_ready", bus.O_Ready, 1'b1);
        rst_n = 1'b1;

        // Plain issue reading an untouched register
        set_instr(1, 2, 0, 0, 0, 0); step();
        idle(); step();

        // RAW on R3: stall until the writeback, which is bypassed
        set_instr(0, 0, 0, 0, 1, 3); step();
        set_instr(1, 3, 0, 0, 0, 0); step(); step();
        set_wb(0, 3, 32'h55, 1'b0); step();
        idle(); step();

        // Pending-counter limit on R4
        repeat (3) begin set_instr(0, 0, 0, 0, 1, 4); step(); end
        set_instr(0, 0, 0, 0, 1, 4); set_wb(0, 4, 32'h44, 1'b0); step();
        bus.I_WbEn = '0; step();
        idle(); set_wb(0, 4, 32'h1, 1'b0); set_wb(1, 4, 32'h2, 1'b0); step();
        idle(); set_wb(0, 4, 32'h3, 1'b0); step();

        // Both ports retire R5 together; port 1 wins and is bypassed
        repeat (2) begin set_instr(0, 0, 0, 0, 1, 5); step(); end
        set_instr(1, 5, 0, 0, 0, 0); set_wb(0, 5, 32'h11, 1'b0); set_wb(1, 5, 32'h22, 1'b0); step();
        set_instr(0, 0, 1, 5, 0, 0); step();
        idle(); step();

        // Condition code: negative, then two ports with port 1 winning
        repeat (3) begin set_instr(0, 0, 0, 0, 1, 6); step(); end
        idle(); set_wb(0, 6, 32'hFFFF_FFFF, 1'b1); step();
        idle(); step();
        idle(); set_wb(0, 6, 32'h5, 1'b1); set_wb(1, 6, 32'h0, 1'b1); step();
        idle(); step();

        // Back-pressure hold, then asynchronous reset mid-hold
        set_instr(0, 0, 0, 0, 1, 7); step();
        set_instr(1, 1, 0, 0, 0, 0); bus.I_Ready = 1'b0; step(); step(); step();
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_o_valid", bus.O_Valid, 1'b0);
        check("async_reset_stall_count", bus.O_StallCount, 32'd0);
        check("async_reset_o_cc", bus.O_CC, 3'b000);
        model_reset();
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        set_instr(1, 7, 0, 0, 1, 7); step();
        idle(); step();

        // Randomised traffic over a small register window to force hazards
        for (int cyc = 0; cyc < 500; cyc++) begin
            idle();
            if ($urandom_range(0, 3) != 0)
                set_instr($urandom_range(0, 1) == 1, $urandom_range(0, 5),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 5),
                          $urandom_range(0, 2) != 0, $urandom_range(0, 5));
            bus.I_Ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NR; i++) avail[i] = m_pend[i];
            for (int p = 0; p < NW; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    r = $urandom_range(0, 5);
                    if (avail[r] > 0) begin
                        case ($urandom_range(0, 3))
                            0:       data = 32'h0;
                            1:       data = 32'hFFFF_FFF0;
                            default: data = $urandom;
                        endcase
                        set_wb(p, r, data, $urandom_range(0, 1) == 1);
                        avail[r]--;
                    end
                end
            end
            step();
        end

        idle();
        repeat (4) step();
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
